// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like slave port between the instruction
// requester (m0) and the data requester (m1). Address handshakes are granted
// by fixed priority (m1 over m0) and the grant is held until addr_ok. The owner
// of every accepted transaction is queued in order, and each slave data_ok is
// steered back to the master that issued that transaction.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        busy,
  output logic        resp_err
);

  localparam int PTR_W = $clog2(OUTSTANDING);

  // Owner of each outstanding transaction: 0 = m0, 1 = m1.
  logic [OUTSTANDING-1:0] fifo_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   lock_valid_r;
  logic                   lock_id_r;
  logic                   resp_err_r;

  logic full_s;
  logic empty_s;
  logic gnt_s;
  logic gnt_req_s;
  logic any_req_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  assign full_s    = (count_r == CNT_W'(OUTSTANDING));
  assign empty_s   = (count_r == CNT_W'(0));
  assign any_req_s = m0_req | m1_req;
  assign gnt_req_s = gnt_s ? m1_req : m0_req;
  assign head_s    = fifo_r[rd_ptr_r];

  // Hold the slave request off while the ID FIFO cannot take another entry.
  assign s_req  = gnt_req_s & ~full_s;
  assign push_s = s_req & s_addr_ok;
  assign pop_s  = s_data_ok & ~empty_s;

  assign m0_addr_ok = push_s & ~gnt_s;
  assign m1_addr_ok = push_s & gnt_s;
  assign m0_data_ok = pop_s & ~head_s;
  assign m1_data_ok = pop_s & head_s;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign busy       = ~empty_s;
  assign resp_err   = resp_err_r;

  // Grant selection: a pending lock wins, otherwise data (m1) beats inst (m0).
  always_comb begin
    gnt_s = 1'b0;
    if (lock_valid_r) begin
      gnt_s = lock_id_r;
    end else if (m1_req) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Slave request fields follow the granted master; idle bus drives zeros.
  always_comb begin
    s_wr    = 1'b0;
    s_size  = 2'd0;
    s_wstrb = 4'd0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    if (any_req_s) begin
      if (gnt_s) begin
        s_wr    = m1_wr;
        s_size  = m1_size;
        s_wstrb = m1_wstrb;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end else begin
        s_wr    = m0_wr;
        s_size  = m0_size;
        s_wstrb = m0_wstrb;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
    end else begin
      s_wr    = 1'b0;
      s_size  = 2'd0;
      s_wstrb = 4'd0;
      s_addr  = 32'd0;
      s_wdata = 32'd0;
    end
  end

  // ID FIFO, occupancy counter, grant lock and sticky response error.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_r       <= {OUTSTANDING{1'b0}};
      rd_ptr_r     <= PTR_W'(0);
      wr_ptr_r     <= PTR_W'(0);
      count_r      <= CNT_W'(0);
      lock_valid_r <= 1'b0;
      lock_id_r    <= 1'b0;
      resp_err_r   <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= gnt_s;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      // Lock while a request waits for addr_ok; a dropped request or a
      // completed handshake releases it. A full FIFO freezes the lock.
      if (!full_s) begin
        lock_valid_r <= s_req & ~s_addr_ok;
        lock_id_r    <= gnt_s;
      end
      if (s_data_ok && empty_s) begin
        resp_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized scoreboard bench for sram_like_arbiter. A driver issues master and
// slave stimulus, checks the address side against a reference model, and queues
// the owner of every accepted transaction; a monitor pops that queue whenever a
// response is delivered and checks the routing.
module tb_sram_like_arbiter;

  localparam int OUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mreq, mwr;
  logic [1:0][1:0]   msize;
  logic [1:0][3:0]   mwstrb;
  logic [1:0][31:0]  maddr, mwdata;
  logic              m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              s_req, s_wr;
  logic [1:0]        s_size;
  logic [3:0]        s_wstrb;
  logic [31:0]       s_addr, s_wdata, s_rdata;
  logic              s_addr_ok, s_data_ok;
  logic              busy, resp_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: owners of accepted transactions in slave order, the
  // master that must keep the grant (-1 = none), and the sticky error.
  bit exp_q[$];
  int lock_m = -1;
  bit err_m  = 1'b0;
  bit [1:0] pend = 2'b00;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(OUT), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .m0_req(mreq[0]), .m0_wr(mwr[0]), .m0_size(msize[0]), .m0_wstrb(mwstrb[0]),
    .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(mreq[1]), .m1_wr(mwr[1]), .m1_size(msize[1]), .m1_wstrb(mwstrb[1]),
    .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .busy(busy), .resp_err(resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Set one master's request; a fresh request gets fresh random fields.
  task automatic set_m(input int i, input bit r);
    if (r && !pend[i]) begin
      maddr[i]  = $urandom;
      mwdata[i] = $urandom;
      mwr[i]    = 1'($urandom_range(0, 1));
      msize[i]  = 2'($urandom_range(0, 2));
      mwstrb[i] = 4'($urandom_range(0, 15));
    end
    pend[i] = r;
    mreq[i] = r;
  endtask

  // One clock: check the address side mid-cycle, then update the model at the edge.
  task automatic step();
    int  g;
    bit  full, esreq, hs, any, err_set;
    #1;
    full  = (exp_q.size() == OUT);
    g     = (lock_m >= 0) ? lock_m : (mreq[1] ? 1 : 0);
    esreq = mreq[g] && !full;
    hs    = esreq && s_addr_ok;
    any   = |mreq;
    check("s_req", s_req, esreq);
    check("m0_addr_ok", m0_addr_ok, hs && g == 0);
    check("m1_addr_ok", m1_addr_ok, hs && g == 1);
    check("s_addr", s_addr, any ? maddr[g] : 32'h0);
    check("s_wdata", s_wdata, any ? mwdata[g] : 32'h0);
    check("s_ctl", {s_wr, s_size, s_wstrb}, any ? {mwr[g], msize[g], mwstrb[g]} : 7'h0);
    check("busy", busy, exp_q.size() != 0);
    check("resp_err", resp_err, err_m);
    err_set = s_data_ok && exp_q.size() == 0;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      lock_m = -1;
      err_m  = 1'b0;
    end else begin
      if (hs) begin
        exp_q.push_back(g[0]);
        pend[g] = 1'b0;
      end
      if (!full) lock_m = (esreq && !s_addr_ok) ? g : -1;
      if (err_set) err_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic apply(input bit r0, input bit r1, input bit aok, input bit dok);
    set_m(0, r0);
    set_m(1, r1);
    s_addr_ok = aok;
    s_data_ok = dok;
    s_rdata   = $urandom;
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && exp_q.size() > 0; k++) apply(1'b0, 1'b0, 1'b0, 1'b1);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses still queued", exp_q.size());
    end
  endtask

  // Monitor: every slave response must reach the queued owner, with s_rdata.
  always @(negedge clk) begin
    bit own;
    #2;
    if (!reset) begin
      if (s_data_ok && exp_q.size() > 0) begin
        own = exp_q.pop_front();
        check("data_ok_owner", {30'd0, m1_data_ok, m0_data_ok}, own ? 32'd2 : 32'd1);
        check("rdata", own ? m1_rdata : m0_rdata, s_rdata);
      end else if (s_data_ok || m0_data_ok || m1_data_ok) begin
        check("spurious_data_ok", {30'd0, m1_data_ok, m0_data_ok}, 32'd0);
      end
    end
  end

  initial begin
    int pd;
    reset = 1'b1;
    mreq = 2'b00; mwr = 2'b00; msize = '0; mwstrb = '0; maddr = '0; mwdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset, then a single inst fetch and its response.
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    set_m(0, 1'b1);
    maddr[0] = 32'hBFC0_0000;
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    set_m(0, 1'b0);
    s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h3C01_0000;
    step();

    // Both request from idle: data first, inst next cycle, responses in order.
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // Locked inst request keeps the grant while data request arrives.
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Fill to OUT, block a fifth, pop once (no push in that cycle), then wrap.
    repeat (4) apply(1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    // Simultaneous push and pop at two outstanding.
    repeat (2) apply(1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // Randomized traffic with occasional dropped requests.
    for (int c = 0; c < 3000; c++) begin
      pd = (c < 1500) ? 7 : 1;
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && $urandom_range(0, 63) == 0) set_m(i, 1'b0);
        else if (!pend[i]) set_m(i, $urandom_range(0, 99) < 40);
        else set_m(i, 1'b1);
      end
      s_addr_ok = 1'($urandom_range(0, 1));
      s_data_ok = (exp_q.size() > 0) && ($urandom_range(0, pd) == 0);
      s_rdata   = $urandom;
      step();
    end
    drain();

    // Response with nothing outstanding sets the sticky error.
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with three outstanding clears everything.
    repeat (3) apply(1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
